// File: rtl/spart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : spart_rx_if
//  Purpose  : Receive-buffer bus between spart_rx and the SPART bus interface.
//             The bus side consumes the byte and acknowledges with clr_rda.
//  Revision : 1.0  initial release
// ============================================================================
interface spart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 clr_rda;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 frm_err;
  logic                 overrun;

  // Bus-interface side: reads the buffer, issues the acknowledge.
  modport master (
    output clr_rda,
    input  rx_data, rda, frm_err, overrun
  );

  // Receiver side: presents the buffer, observes the acknowledge.
  modport slave (
    input  clr_rda,
    output rx_data, rda, frm_err, overrun
  );
endinterface
`default_nettype wire

// File: rtl/spart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : spart_rx
//  Purpose  : SPART receive datapath. Oversamples rxd with the baud enable,
//             frames 8N1 characters LSB first and holds the last byte plus
//             rda / frm_err / overrun status for the bus interface.
//  Revision : 1.0  initial release
// ============================================================================
module spart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,      // asynchronous, active low
  input  wire logic      enable,   // one-clk baud tick, OVERSAMPLE per bit
  input  wire logic      rxd,      // raw serial input, idle high
  spart_rx_if.slave      bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 sync1_q, sync2_q;
  logic                 rxd_s;
  logic                 done;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rda_q, rda_d;
  logic                 frm_err_q, frm_err_d;
  logic                 overrun_q, overrun_d;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s = sync2_q;

  // Frame state, counters and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Framing sequence: everything advances only on baud ticks.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done    = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == TICK_MID) begin
            // A line back high at mid start bit was only a glitch.
            tick_d  = '0;
            bit_d   = '0;
            state_d = rxd_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == TICK_END) begin
            // LSB arrives first: shift right, new bit enters at the MSB.
            shift_d = DATA_BITS'({rxd_s, shift_q} >> 1);
            tick_d  = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_q == TICK_END) begin
            done    = 1'b1;
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  // Status next-state: frame completion takes priority over clr_rda.
  always_comb begin
    rx_data_d = rx_data_q;
    rda_d     = rda_q;
    frm_err_d = frm_err_q;
    overrun_d = overrun_q;
    if (done) begin
      rx_data_d = shift_q;
      rda_d     = 1'b1;
      frm_err_d = ~rxd_s;
      // A simultaneous read consumed the old byte, so nothing was lost.
      overrun_d = bus.clr_rda ? 1'b0 : (overrun_q | rda_q);
    end else if (bus.clr_rda) begin
      rda_d     = 1'b0;
      frm_err_d = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // Registered receive buffer and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q <= '0;
      rda_q     <= 1'b0;
      frm_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      frm_err_q <= frm_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rda     = rda_q;
  assign bus.frm_err = frm_err_q;
  assign bus.overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spart_rx
//  Purpose  : Self-checking bench for spart_rx. Builds a per-cycle line,
//             reset and clr_rda timeline, derives the expected status per
//             clock from the framing rules, then replays and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spart_rx;

  localparam int NMAX = 16384;
  localparam int BITP = 64;    // clk per bit: enable every 4 clk, 16 ticks

  logic clk;
  logic rst;
  logic enable;
  logic rxd;

  spart_rx_if #(.DATA_BITS(8)) bus ();

  spart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .rxd    (rxd),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus timeline, indexed by clock edge number.
  bit       line_a [NMAX];
  bit       rst_a  [NMAX];
  bit       clr_a  [NMAX];
  // Reference completions and expected outputs.
  bit       cv_a   [NMAX];
  bit [7:0] cb_a   [NMAX];
  bit       cf_a   [NMAX];
  bit [7:0] e_rx   [NMAX];
  bit       e_rda  [NMAX];
  bit       e_fe   [NMAX];
  bit       e_ov   [NMAX];

  int comp_q[$];
  int pol_q[$];
  int bp;
  int n_edges;
  int cur_k;
  int n_vec;
  int n_err;

  // Single comparison point for every check.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, cur_k, obs, exp);
    end
  endtask

  task automatic put(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      if (bp < NMAX) line_a[bp] = v;
      bp++;
    end
  endtask

  // pol: -2 = frame not expected to complete, -1 = never read,
  // otherwise clr_rda that many clk after completion.
  task automatic put_frame(input bit [7:0] b, input bit stop, input int pol);
    put(1'b0, BITP);
    for (int i = 0; i < 8; i++) put(b[i], BITP);
    put(stop, BITP);
    if (pol != -2) pol_q.push_back(pol);
  endtask

  // Value seen by the receiver's sampling logic at edge k.
  function automatic bit rxs(input int k);
    if (k < 2) return 1'b1;
    if (rst_a[k-1] || rst_a[k-2]) return 1'b1;
    return line_a[k-2];
  endfunction

  function automatic int rst_in(input int a, input int b);
    for (int k = a; k <= b && k < n_edges; k++)
      if (rst_a[k]) return k;
    return -1;
  endfunction

  function automatic int after_rst(input int k);
    int j;
    j = k;
    while (j < n_edges && rst_a[j]) j++;
    return j;
  endfunction

  // Locate every character the line carries, in absolute time.
  task automatic run_model();
    int pos, e, s, c, r;
    bit [7:0] b;
    pos = 0;
    while (pos < n_edges) begin
      e = pos;
      while (e < n_edges && !((e % 4 == 0) && !rst_a[e] && !rxs(e))) e++;
      if (e >= n_edges) break;
      s = e + 32;                      // half a bit after the detected edge
      if (s >= n_edges) break;
      r = rst_in(e + 1, s);
      if (r >= 0) begin pos = after_rst(r); continue; end
      if (rxs(s)) begin pos = s + 1; continue; end
      c = s + 9 * BITP;                // middle of the stop bit
      if (c >= n_edges) break;
      r = rst_in(s + 1, c);
      if (r >= 0) begin pos = after_rst(r); continue; end
      for (int j = 0; j < 8; j++) b[j] = rxs(s + BITP * (j + 1));
      cv_a[c] = 1'b1;
      cb_a[c] = b;
      cf_a[c] = !rxs(c);
      comp_q.push_back(c);
      pos = c + 1;
    end
  endtask

  task automatic place_clr();
    int p;
    for (int i = 0; i < comp_q.size(); i++) begin
      p = (i < pol_q.size()) ? pol_q[i] : -1;
      if (p >= 0 && comp_q[i] + p < n_edges) clr_a[comp_q[i] + p] = 1'b1;
    end
  endtask

  task automatic build_expect();
    bit [7:0] rx_m;
    bit rda_m, fe_m, ov_m;
    rx_m = 8'h00; rda_m = 1'b0; fe_m = 1'b0; ov_m = 1'b0;
    for (int k = 0; k < n_edges; k++) begin
      if (rst_a[k]) begin
        rx_m = 8'h00; rda_m = 1'b0; fe_m = 1'b0; ov_m = 1'b0;
      end else if (cv_a[k]) begin
        ov_m  = clr_a[k] ? 1'b0 : (ov_m | rda_m);
        rx_m  = cb_a[k];
        rda_m = 1'b1;
        fe_m  = cf_a[k];
      end else if (clr_a[k]) begin
        rda_m = 1'b0; fe_m = 1'b0; ov_m = 1'b0;
      end
      e_rx[k] = rx_m; e_rda[k] = rda_m; e_fe[k] = fe_m; e_ov[k] = ov_m;
    end
  endtask

  initial begin
    int p, pol;
    n_vec = 0; n_err = 0; bp = 0;
    rst = 1'b0; enable = 1'b0; rxd = 1'b1; bus.clr_rda = 1'b0;
    for (int k = 0; k < NMAX; k++) begin
      line_a[k] = 1'b1; rst_a[k] = 1'b0; clr_a[k] = 1'b0; cv_a[k] = 1'b0;
    end
    for (int k = 0; k < 10; k++) rst_a[k] = 1'b1;

    put(1'b1, 30);
    // Plain character, then read.
    put_frame(8'hA5, 1'b1, 10);  put(1'b1, 100);
    // Short low glitch, then a good character.
    put(1'b0, 20);               put(1'b1, 100);
    put_frame(8'h3C, 1'b1, 10);  put(1'b1, 100);
    // Framing error.
    put_frame(8'h55, 1'b0, 10);  put(1'b1, 100);
    // Overrun, then clr_rda on the exact completion edge.
    put_frame(8'h11, 1'b1, -1);  put(1'b1, 40);
    put_frame(8'h22, 1'b1, 10);  put(1'b1, 100);
    put_frame(8'h11, 1'b1, -1);  put(1'b1, 40);
    put_frame(8'h22, 1'b1, 0);   put(1'b1, 100);
    // Reset during data bit 4.
    p = bp;
    put_frame(8'hFF, 1'b1, -2);
    for (int k = p + 5 * BITP + 20; k < p + 5 * BITP + 28; k++) rst_a[k] = 1'b1;
    put(1'b1, 100);
    put_frame(8'h81, 1'b1, 10);  put(1'b1, 100);
    // Back-to-back characters.
    put_frame(8'h00, 1'b1, 10);
    put_frame(8'hFF, 1'b1, 10);
    put_frame(8'h0F, 1'b1, 10);  put(1'b1, 100);
    // Random characters, stop bits, gaps and read timing.
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 3))
        0:       pol = -1;
        1:       pol = 0;
        default: pol = $urandom_range(1, 300);
      endcase
      put_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), pol);
      put(1'b1, $urandom_range(0, 120));
    end
    put(1'b1, 700);
    n_edges = (bp < NMAX) ? bp : NMAX;

    run_model();
    place_clr();
    build_expect();

    for (int k = 0; k < n_edges; k++) begin
      rst         = !rst_a[k];
      rxd         = line_a[k];
      enable      = (k % 4 == 0);
      bus.clr_rda = clr_a[k];
      @(posedge clk);
      #1;
      cur_k = k;
      check_val("rda",     32'(bus.rda),     32'(e_rda[k]));
      check_val("rx_data", 32'(bus.rx_data), 32'(e_rx[k]));
      check_val("frm_err", 32'(bus.frm_err), 32'(e_fe[k]));
      check_val("overrun", 32'(bus.overrun), 32'(e_ov[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
